apb_master_multi: RTL and testbench



---
 rtl/apb_master_multi.sv | 161 ++++++++++++++++
 tb/tb_apb_master_multi.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_multi.sv
// APB (AMBA 3) bridge master driving NUM_SLAVES peripherals from a valid/ready request port.
// Optional wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_multi #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_MSB    = ADDR_W - 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic                         PWRITE,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam logic [SEL_W:0] NUM_SLAVES_L = (SEL_W + 1)'(NUM_SLAVES);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = {{(NUM_SLAVES - 1){1'b0}}, 1'b1};

  if (NUM_SLAVES < 2 || NUM_SLAVES > 16 || TIMEOUT < 1) begin : g_bad_params
    $error("apb_master_multi: NUM_SLAVES must be 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                  state, state_d;
  logic [SEL_W-1:0]        req_idx, acc_idx;
  logic [ADDR_W-1:0]       paddr_d;
  logic [DATA_W-1:0]       pwdata_d, rsp_rdata_d, acc_rdata;
  logic                    pwrite_d, penable_d, req_ready_d, rsp_valid_d, rsp_err_d;
  logic [NUM_SLAVES-1:0]   psel_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
`endif

  // The slave index is re-derived from PADDR, which is held for the whole transfer.
  assign req_idx   = req_addr[SEL_MSB -: SEL_W];
  assign acc_idx   = PADDR[SEL_MSB -: SEL_W];
  assign acc_rdata = PRDATA[int'(acc_idx) * DATA_W +: DATA_W];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    pwrite_d    = PWRITE;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    req_ready_d = req_ready;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          pwrite_d    = req_write;
          req_ready_d = 1'b0;
          if ({1'b0, req_idx} < NUM_SLAVES_L) begin
            psel_d  = SEL_ONE << req_idx;
            state_d = SETUP;
          end else begin
            state_d = DERR;
          end
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        state_d    = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (PREADY[acc_idx]) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR[acc_idx];
          rsp_rdata_d = PWRITE ? '0 : acc_rdata;
          psel_d      = '0;
          penable_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
`endif
      end
      DERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PWRITE    <= pwrite_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_multi.sv
// Randomized self-checking bench for apb_master_multi with a cycle-timeline reference model.
// Three slaves are configured so that slave index 3 exercises the decode-error path.
module tb_apb_master_multi;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int SW = $clog2(NS);
  localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic             req_valid, req_ready, req_write;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata;
  logic             rsp_valid, rsp_err;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic             PWRITE, PENABLE;
  logic [NS-1:0]    PSEL, PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_multi #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_MSB(AW - 1), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Slave bus model: unselected slaves and not-ready cycles carry random noise.
  task automatic drive_slaves(input int tgt, input bit rdy, input bit err, input logic [DW-1:0] rdata);
    logic [NS-1:0] r, e;
    r = NS'($urandom);
    e = NS'($urandom);
    for (int k = 0; k < NS; k++) PRDATA[k*DW +: DW] = $urandom;
    if (tgt < NS) begin
      r[tgt] = rdy;
      if (rdy) e[tgt] = err;
      PRDATA[tgt*DW +: DW] = rdata;
    end
    PREADY  = r;
    PSLVERR = e;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    check("req_ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // One complete transfer; called at a falling edge, returns at the falling edge of the response cycle.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input bit serr, input logic [DW-1:0] rdata);
    logic [AW-1:0] a;
    int            idx, alen;
    bit            derr, tmo;
    logic [NS-1:0] onehot;
    a      = addr;
    idx    = int'(a[AW-1 -: SW]);
    derr   = (idx >= NS);
    tmo    = !derr && TO_EN && (waits >= TO);
    alen   = tmo ? TO : waits + 1;
    onehot = derr ? '0 : NS'(1 << idx);

    issue(wr, addr, wdata);
    drive_slaves(idx, 1'b0, 1'b0, rdata);
    @(negedge PCLK);
    req_valid = 1'b0;
    req_write = $urandom;
    req_addr  = $urandom;
    req_wdata = $urandom;
    check("c1_psel", PSEL, onehot);
    check("c1_penable", PENABLE, 1'b0);
    check("c1_req_ready", req_ready, 1'b0);
    check("c1_rsp_valid", rsp_valid, 1'b0);
    if (!derr) begin
      check("setup_paddr", PADDR, addr);
      check("setup_pwdata", PWDATA, wdata);
      check("setup_pwrite", PWRITE, wr);
      drive_slaves(idx, 1'($urandom), 1'($urandom), rdata);
      for (int j = 1; j <= alen; j++) begin
        @(negedge PCLK);
        check("access_psel", PSEL, onehot);
        check("access_penable", PENABLE, 1'b1);
        check("access_paddr", PADDR, addr);
        check("access_rsp_valid", rsp_valid, 1'b0);
        drive_slaves(idx, !tmo && (j == alen), serr, rdata);
      end
    end
    @(negedge PCLK);
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_err", rsp_err, derr || tmo || serr);
    check("rsp_rdata", rsp_rdata, (derr || tmo || wr) ? '0 : rdata);
    check("rsp_psel", PSEL, '0);
    check("rsp_penable", PENABLE, 1'b0);
    check("rsp_req_ready", req_ready, 1'b1);
    check("rsp_paddr_hold", PADDR, addr);
  endtask

  task automatic reset_mid_access();
    issue(1'b0, 32'h4000_0000, 32'h0);
    drive_slaves(1, 1'b0, 1'b0, 32'h1234_5678);
    @(negedge PCLK);
    req_valid = 1'b0;
    check("rst_setup_psel", PSEL, 3'b010);
    drive_slaves(1, 1'b0, 1'b0, 32'h1234_5678);
    repeat (3) begin
      @(negedge PCLK);
      check("rst_access_penable", PENABLE, 1'b1);
      drive_slaves(1, 1'b0, 1'b0, 32'h1234_5678);
    end
    #2 PRESET = 1'b1;
    #1;
    check("rst_async_psel", PSEL, '0);
    check("rst_async_penable", PENABLE, 1'b0);
    check("rst_async_req_ready", req_ready, 1'b1);
    check("rst_async_rsp_valid", rsp_valid, 1'b0);
    @(negedge PCLK);
    PRESET = 1'b0;
    drive_slaves(1, 1'b1, 1'b0, 32'h1234_5678);
    repeat (4) begin
      @(negedge PCLK);
      check("post_rst_rsp_valid", rsp_valid, 1'b0);
      check("post_rst_psel", PSEL, '0);
    end
  endtask

  initial begin
    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = '0;
    PSLVERR   = '0;
    PRDATA    = '0;
    repeat (2) @(negedge PCLK);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, '0);
    check("reset_paddr", PADDR, '0);
    check("reset_pwdata", PWDATA, '0);
    check("reset_pwrite", PWRITE, 1'b0);
    check("reset_psel", PSEL, '0);
    check("reset_penable", PENABLE, 1'b0);
    PRESET = 1'b0;
    @(negedge PCLK);

    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    run_txn(1'b0, 32'h4000_0004, 32'h0, 2, 1'b0, 32'h0000_F555);
    run_txn(1'b0, 32'h8000_0020, 32'h0, 0, 1'b1, 32'hA5A5_0F0F);
    run_txn(1'b0, 32'hC000_0000, 32'h0, 0, 1'b0, 32'h0);
    run_txn(1'b0, 32'h4000_0008, 32'h0, 100, 1'b0, 32'h0BAD_CAFE);
    reset_mid_access();

    for (int n = 0; n < 60; n++) begin
      logic [1:0] s;
      int         w;
      s = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      run_txn(1'($urandom), {s, 30'($urandom)}, $urandom, w, 1'($urandom), $urandom);
      repeat ($urandom_range(0, 1)) begin
        @(negedge PCLK);
        check("idle_req_ready", req_ready, 1'b1);
        check("idle_rsp_valid", rsp_valid, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
